// File: rtl/mdu_unit_if.sv
// MDU issue/result bundle between the E-stage and the multiply/divide unit.
interface mdu_unit_if;
    logic        start;
    logic [2:0]  mdu_op;
    logic [31:0] MFRSE;
    logic [31:0] MFRTE;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (output start, output mdu_op, output MFRSE, output MFRTE,
                    input busy, input HI, input LO);
    modport slave  (input start, input mdu_op, input MFRSE, input MFRTE,
                    output busy, output HI, output LO);
endinterface

// File: rtl/mdu_unit.sv
// Multi-cycle MIPS HI/LO unit: mult/multu/div/divu plus mthi/mtlo (divider built only with MDU_DIV_EN).
// Latency: mult/multu 5 cycles, div/divu 10 cycles to HI/LO commit; mthi/mtlo write at the issue edge.
// Backpressure: busy stalls the issuing stage; start seen while busy is dropped.
module mdu_unit (
    input  logic        clk,
    input  logic        reset,
    mdu_unit_if.slave   mdu
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] hi_tmp_q, hi_tmp_d, lo_tmp_q, lo_tmp_d;
    logic        commit_q, commit_d;

    logic [63:0] prod_s, prod_u;

    assign prod_s = $signed({{32{mdu.MFRSE[31]}}, mdu.MFRSE}) *
                    $signed({{32{mdu.MFRTE[31]}}, mdu.MFRTE});
    assign prod_u = {32'd0, mdu.MFRSE} * {32'd0, mdu.MFRTE};

`ifdef MDU_DIV_EN
    // One unsigned divider serves both flavours: signed div runs on magnitudes
    // and re-applies signs. 0x80000000/-1 falls out as 0x80000000 rem 0.
    logic        is_signed, rs_neg, rt_neg, div_zero;
    logic [31:0] div_a, div_b, uq, ur, quo, rem;

    assign is_signed = (mdu.mdu_op == 3'd2);
    assign rs_neg    = is_signed & mdu.MFRSE[31];
    assign rt_neg    = is_signed & mdu.MFRTE[31];
    assign div_zero  = (mdu.MFRTE == 32'd0);
    assign div_a     = rs_neg ? (~mdu.MFRSE + 32'd1) : mdu.MFRSE;
    assign div_b     = div_zero ? 32'd1 : (rt_neg ? (~mdu.MFRTE + 32'd1) : mdu.MFRTE);
    assign uq        = div_a / div_b;
    assign ur        = div_a % div_b;
    assign quo       = (rs_neg ^ rt_neg) ? (~uq + 32'd1) : uq;
    assign rem       = rs_neg ? (~ur + 32'd1) : ur;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        hi_tmp_d = hi_tmp_q;
        lo_tmp_d = lo_tmp_q;
        commit_d = commit_q;
        case (state_q)
            IDLE: begin
                if (mdu.start) begin
                    case (mdu.mdu_op)
                        3'd0: begin
                            state_d  = BUSY;
                            cnt_d    = 4'd5;
                            {hi_tmp_d, lo_tmp_d} = prod_s;
                            commit_d = 1'b1;
                        end
                        3'd1: begin
                            state_d  = BUSY;
                            cnt_d    = 4'd5;
                            {hi_tmp_d, lo_tmp_d} = prod_u;
                            commit_d = 1'b1;
                        end
`ifdef MDU_DIV_EN
                        3'd2, 3'd3: begin
                            state_d  = BUSY;
                            cnt_d    = 4'd10;
                            hi_tmp_d = rem;
                            lo_tmp_d = quo;
                            commit_d = ~div_zero;
                        end
`endif
                        3'd4:    hi_d = mdu.MFRSE;
                        3'd5:    lo_d = mdu.MFRSE;
                        default: ;
                    endcase
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = IDLE;
                    if (commit_q) begin
                        hi_d = hi_tmp_q;
                        lo_d = lo_tmp_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            hi_tmp_q <= 32'd0;
            lo_tmp_q <= 32'd0;
            commit_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            hi_tmp_q <= hi_tmp_d;
            lo_tmp_q <= lo_tmp_d;
            commit_q <= commit_d;
        end
    end

    assign mdu.busy = (state_q == BUSY);
    assign mdu.HI   = hi_q;
    assign mdu.LO   = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Directed scenarios plus random issue traffic against a cycle-count/arithmetic reference model.
module tb_mdu_unit;

    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    mdu_unit_if m ();

    mdu_unit dut (
        .clk   (clk),
        .reset (reset),
        .mdu   (m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference state: architectural HI/LO, cycles left, pending result
    logic [31:0] e_hi, e_lo, p_hi, p_lo;
    int          left;
    logic        p_ok;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        longint      sa, sb, prod;
        logic [63:0] up;
        sa = longint'($signed(m.MFRSE));
        sb = longint'($signed(m.MFRTE));
        if (!reset) begin
            e_hi = 0; e_lo = 0; left = 0; p_ok = 0;
        end else if (left > 0) begin
            left--;
            if (left == 0 && p_ok) begin
                e_hi = p_hi; e_lo = p_lo;
            end
        end else if (m.start) begin
            case (m.mdu_op)
                3'd0: begin prod = sa * sb; {p_hi, p_lo} = prod; left = 5; p_ok = 1; end
                3'd1: begin up = {32'd0, m.MFRSE} * {32'd0, m.MFRTE}; {p_hi, p_lo} = up; left = 5; p_ok = 1; end
`ifdef MDU_DIV_EN
                3'd2: begin
                    left = 10; p_ok = (m.MFRTE != 0);
                    if (p_ok) begin p_lo = 32'(sa / sb); p_hi = 32'(sa % sb); end
                end
                3'd3: begin
                    left = 10; p_ok = (m.MFRTE != 0);
                    if (p_ok) begin p_lo = m.MFRSE / m.MFRTE; p_hi = m.MFRSE % m.MFRTE; end
                end
`endif
                3'd4: e_hi = m.MFRSE;
                3'd5: e_lo = m.MFRSE;
                default: ;
            endcase
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_val("busy", 32'(m.busy), 32'(left > 0));
        check_val("hi", m.HI, e_hi);
        check_val("lo", m.LO, e_lo);
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        m.start = 1'b1; m.mdu_op = op; m.MFRSE = a; m.MFRTE = b;
        step();
        m.start = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        e_hi = 0; e_lo = 0; p_hi = 0; p_lo = 0; left = 0; p_ok = 0;
        reset = 1'b0; m.start = 1'b1; m.mdu_op = 3'd0; m.MFRSE = 32'd5; m.MFRTE = 32'd5;
        step();
        m.start = 1'b0;
        step();
        check_val("rst_busy", 32'(m.busy), 32'd0);
        check_val("rst_hi", m.HI, 32'd0);
        reset = 1'b1;
        step();

        // signed mult -2*3
        issue(3'd0, 32'hFFFF_FFFE, 32'd3);
        repeat (4) begin
            step();
            check_val("s1_hold", m.LO, 32'd0);
        end
        step();
        check_val("s1_hi", m.HI, 32'hFFFF_FFFF);
        check_val("s1_lo", m.LO, 32'hFFFF_FFFA);
        check_val("s1_idle", 32'(m.busy), 32'd0);

        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (5) step();
        check_val("s2_hi", m.HI, 32'hFFFF_FFFE);
        check_val("s2_lo", m.LO, 32'h0000_0001);

`ifdef MDU_DIV_EN
        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        repeat (9) step();
        check_val("s3_busy9", 32'(m.busy), 32'd1);
        step();
        check_val("s3_lo", m.LO, 32'hFFFF_FFFD);
        check_val("s3_hi", m.HI, 32'hFFFF_FFFF);

        issue(3'd2, 32'hFFFF_FFF9, 32'd0);
        repeat (9) step();
        check_val("s3z_busy9", 32'(m.busy), 32'd1);
        step();
        check_val("s3z_lo", m.LO, 32'hFFFF_FFFD);
        check_val("s3z_hi", m.HI, 32'hFFFF_FFFF);

        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        repeat (10) step();
        check_val("ovf_lo", m.LO, 32'h8000_0000);
        check_val("ovf_hi", m.HI, 32'h0);

        issue(3'd3, 32'd100, 32'd7);
        repeat (2) step();
        issue(3'd4, 32'h1234_5678, 32'd0);
        repeat (7) step();
        check_val("s4_hi", m.HI, 32'd2);
        check_val("s4_lo", m.LO, 32'd14);
`else
        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        check_val("s6_busy", 32'(m.busy), 32'd0);
        step();
        check_val("s6_hi", m.HI, 32'hFFFF_FFFE);
        check_val("s6_lo", m.LO, 32'h0000_0001);
`endif

        issue(3'd5, 32'hA5A5_A5A5, 32'd0);
        check_val("s6_mtlo", m.LO, 32'hA5A5_A5A5);
        check_val("s6_mtlo_busy", 32'(m.busy), 32'd0);
        issue(3'd4, 32'h5A5A_0001, 32'd0);
        check_val("mthi", m.HI, 32'h5A5A_0001);
        issue(3'd7, 32'h1111_1111, 32'd0);
        check_val("op7_hi", m.HI, 32'h5A5A_0001);

        // reset in the middle of a mult
        issue(3'd0, 32'd7, 32'd9);
        repeat (2) step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        check_val("s5_busy", 32'(m.busy), 32'd0);
        check_val("s5_hi", m.HI, 32'd0);
        check_val("s5_lo", m.LO, 32'd0);
        repeat (6) step();
        check_val("s5_nocommit", m.LO, 32'd0);

        for (int i = 0; i < 600; i++) begin
            m.start  = ($urandom_range(0, 2) == 0);
            m.mdu_op = 3'($urandom_range(0, 7));
            m.MFRSE  = pick();
            m.MFRTE  = pick();
            reset    = ($urandom_range(0, 99) != 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mdu_unit.md
MDU_UNIT -- requirements
Module: mdu_unit

Interface
REQ-001 SHALL have a single clock. Reset is synchronous and active-low. Clock and reset ports are named clk and reset, as in the rest of the codebase.
REQ-002 clk  input  1  pipeline clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous active-low reset; reset==0 at an edge clears all state.
REQ-004 start  input  1  E-stage issue strobe for an MDU instruction; sampled on the rising edge.
REQ-005 mdu_op  input  3  operation code: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; 6 and 7 are reserved no-ops.
REQ-006 MFRSE  input  32  forwarded rs operand from the E-stage forwarding mux (dividend, multiplicand, mthi/mtlo source).
REQ-007 MFRTE  input  32  forwarded rt operand from the E-stage forwarding mux (divisor, multiplier).
REQ-008 busy  output  1  operation in flight; the hazard unit stalls D on mult/div/mfhi/mflo/mthi/mtlo while (start&&op<=3)||busy.
REQ-009 HI  output  32  architectural HI register (mfhi source).
REQ-010 LO  output  32  architectural LO register (mflo source).

Function
REQ-011 SHALL implement a two-state FSM: IDLE and BUSY, with a 4-bit down-counter cnt.
- IDLE -> BUSY: start==1, mdu_op in {0,1}, cnt loaded with 5.
- IDLE -> BUSY: start==1, mdu_op in {2,3}, cnt loaded with 10.
REQ-012 At the IDLE->BUSY edge SHALL capture the full 64-bit result into internal hi_tmp/lo_tmp; HI/LO stay unchanged during BUSY.
REQ-013 In BUSY SHALL decrement cnt each edge; on the edge where cnt==1, SHALL commit HI<=hi_tmp and LO<=lo_tmp and return to IDLE.
REQ-014 busy SHALL be high for exactly 5 cycles (mult/multu) or 10 cycles (div/divu) after the start edge, and low in the cycle after the commit edge.
REQ-015 mult SHALL compute a signed 32x32->64 product; multu SHALL compute an unsigned 32x32->64 product; HI=[63:32], LO=[31:0].
REQ-016 div SHALL truncate toward zero (LO=quotient); HI=remainder with the sign of the dividend.
REQ-017 divu SHALL produce an unsigned quotient (LO) and remainder (HI).
REQ-018 Signed overflow 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-019 Divide by zero (MFRTE==0) SHALL still hold busy for 10 cycles and SHALL commit nothing: HI/LO retain their prior values.
REQ-020 mthi/mtlo with start==1 in IDLE SHALL write MFRSE into HI or LO at that edge; busy stays low.
REQ-021 start==1 while BUSY (any op) SHALL be ignored; the in-flight operation and cnt are unaffected.
REQ-022 start==1 with mdu_op 6 or 7 SHALL be a no-op.
REQ-023 HI and LO outputs SHALL be register outputs with no combinational path from inputs.

Reset
REQ-024 reset==0 at an edge SHALL force IDLE, cnt=0, busy=0, HI=0, LO=0, hi_tmp=0, lo_tmp=0, overriding start.
REQ-025 reset==0 during BUSY SHALL abort the operation with no commit; busy is low from the next cycle.

Configuration
REQ-026 Macro MDU_DIV_EN defined: div/divu SHALL be implemented per REQ-011..REQ-019.
REQ-027 MDU_DIV_EN undefined: no divider logic SHALL be synthesized; mdu_op 2/3 SHALL be treated as no-ops (busy stays low, HI/LO unchanged).

Verification
REQ-028 Scenario 1, mult: MFRSE=0xFFFFFFFE (-2), MFRTE=3, start=1 for 1 cycle -> busy high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; HI/LO unchanged during busy.
REQ-029 Scenario 2, multu: MFRSE=0xFFFFFFFF, MFRTE=0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
REQ-030 Scenario 3, div: MFRSE=0xFFFFFFF9 (-7), MFRTE=2 -> busy high for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-031 Scenario 3 repeated with MFRTE=0 -> busy high for 10 cycles, HI/LO unchanged.
REQ-032 Scenario 4, overlapping issue: divu 100/7 issued, then mthi 0x12345678 at busy cycle 3 -> mthi ignored; final HI=2, LO=14 at cycle 10.
REQ-033 Scenario 5, reset abort: mult issued, reset=0 at busy cycle 2 -> next cycle busy=0, HI=0, LO=0; no later commit.
REQ-034 Scenario 6, config: with MDU_DIV_EN undefined, div issued -> busy never asserts, HI/LO unchanged.
REQ-035 Scenario 6, config: mtlo 0xA5A5A5A5 in IDLE -> LO=0xA5A5A5A5 next cycle, busy=0.
